// File: rtl/memoria_pkg.sv
// =============================================================================
// Module      : memoria_pkg
// Description : Shared FSM state type and operation codes for memoria_controlador.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package memoria_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/ram_array.sv
// =============================================================================
// Module      : ram_array
// Description : Single-port word array, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ram_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/memoria_controlador.sv
// =============================================================================
// Module      : memoria_controlador
// Description : Wait-state memory controller (IDLE/WAIT/DONE) around ram_array.
//               Define MEM_BOUNDS_CHECK_EN to add out-of-range detection and
//               the mem_error output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module memoria_controlador
  import memoria_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_op,
  input  logic [31:0]           MAR,
  input  logic [DATA_WIDTH-1:0] MBR_out,
  output logic [DATA_WIDTH-1:0] MBR_in,
  output logic                  mem_ready,
  output logic                  mem_busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                  mem_error
`endif
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    op_q, op_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   rd_value;
  logic                    range_err;
  logic                    ram_we;

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q, oob_d;

  always_comb begin
    oob_d = oob_q;
    if (state_q == IDLE && mem_enable) begin
      oob_d = |MAR[31:ADDR_WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
    end
  end

  assign range_err = oob_q;
  assign mem_error = (state_q == DONE) && oob_q;
`else
  logic unused_mar_hi;
  assign unused_mar_hi = ^MAR[31:ADDR_WIDTH];
  assign range_err     = 1'b0;
`endif

  assign rd_value = range_err ? '0 : ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (mem_enable) begin
          addr_d  = MAR[ADDR_WIDTH-1:0];
          op_d    = mem_op;
          wdata_d = MBR_out;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Read data is captured as DONE ends so MBR_in keeps it afterwards.
        if (op_q == MEM_OP_READ) begin
          hold_d = rd_value;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= MEM_OP_READ;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
    end
  end

  assign ram_we    = (state_q == DONE) && (op_q == MEM_OP_WRITE) && !range_err && !reset;
  assign mem_ready = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);
  assign MBR_in    = ((state_q == DONE) && (op_q == MEM_OP_READ)) ? rd_value : hold_q;

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_memoria_controlador.sv
// =============================================================================
// Module      : tb_memoria_controlador
// Description : Scoreboard bench for memoria_controlador (WAIT_STATES=2 and 0).
//               Honours MEM_BOUNDS_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_memoria_controlador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, op_a, rdy_a, busy_a;
  logic [31:0] mar_a, wd_a, rd_a;
  logic        en_b, op_b, rdy_b, busy_b;
  logic [31:0] mar_b, wd_b, rd_b;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err_a, err_b;
`endif

  memoria_controlador #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut_a (
    .clock(clk), .reset(rst), .mem_enable(en_a), .mem_op(op_a), .MAR(mar_a),
    .MBR_out(wd_a), .MBR_in(rd_a), .mem_ready(rdy_a), .mem_busy(busy_a)
`ifdef MEM_BOUNDS_CHECK_EN
    , .mem_error(err_a)
`endif
  );

  memoria_controlador #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut_b (
    .clock(clk), .reset(rst), .mem_enable(en_b), .mem_op(op_b), .MAR(mar_b),
    .MBR_out(wd_b), .MBR_in(rd_b), .mem_ready(rdy_b), .mem_busy(busy_b)
`ifdef MEM_BOUNDS_CHECK_EN
    , .mem_error(err_b)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  logic [31:0] model_a [int];
  logic [31:0] model_b [int];
  logic [31:0] last_a, last_b;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  always @(negedge clk) begin
    if (rdy_a) begin
      check("sb_pending_a", 32'(q_a.size() != 0), 32'd1);
      check("busy_done_a", 32'(busy_a), 32'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("rdata_a", rd_a, e_a.data);
`ifdef MEM_BOUNDS_CHECK_EN
        check("err_a", 32'(err_a), 32'(e_a.err));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rdy_b) begin
      check("sb_pending_b", 32'(q_b.size() != 0), 32'd1);
      check("busy_done_b", 32'(busy_b), 32'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("rdata_b", rd_b, e_b.data);
`ifdef MEM_BOUNDS_CHECK_EN
        check("err_b", 32'(err_b), 32'(e_b.err));
`endif
      end
    end
  end

  // One complete access; inputs are scrambled right after acceptance.
  task automatic access(input int sel, input logic op, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat);
    exp_t e;
    logic oob;
    int   key;
    int   lat;
    oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    oob = (addr >= 32'd1024);
`endif
    key   = int'(addr[9:0]);
    e.err = oob;
    if (op) begin
      e.data = (sel == 0) ? last_a : last_b;
      if (!oob) begin
        if (sel == 0) model_a[key] = data;
        else          model_b[key] = data;
      end
    end else begin
      if (oob)           e.data = 32'd0;
      else if (sel == 0) e.data = model_a[key];
      else               e.data = model_b[key];
      if (sel == 0) last_a = e.data;
      else          last_b = e.data;
    end
    @(negedge clk);
    if (sel == 0) begin
      en_a = 1'b1; op_a = op; mar_a = addr; wd_a = data; q_a.push_back(e);
    end else begin
      en_b = 1'b1; op_b = op; mar_b = addr; wd_b = data; q_b.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      en_a = 1'b0; op_a = ~op; mar_a = ~addr; wd_a = ~data;
    end else begin
      en_b = 1'b0; op_b = ~op; mar_b = ~addr; wd_b = ~data;
    end
    lat = 1;
    @(negedge clk);
    while (!rdy(sel) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check((sel == 0) ? "latency_a" : "latency_b", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check((sel == 0) ? "idle_after_a" : "idle_after_b", 32'(busy(sel)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   nrdy;
    exp_t e;
    rst  = 1'b1;
    en_a = 1'b0; op_a = 1'b0; mar_a = '0; wd_a = '0;
    en_b = 1'b0; op_b = 1'b0; mar_b = '0; wd_b = '0;
    last_a = '0; last_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mbr_in_a", rd_a, 32'd0);
    check("rst_ready_a", 32'(rdy_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_mbr_in_b", rd_b, 32'd0);
    check("rst_ready_b", 32'(rdy_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("rst_err_a", 32'(err_a), 32'd0);
`endif
    rst = 1'b0;

    access(0, 1'b1, 32'd1, 32'd5, 3);
    access(0, 1'b0, 32'd1, 32'd0, 3);
    access(0, 1'b1, 32'd2, 32'd20, 3);
    access(0, 1'b0, 32'd2, 32'd0, 3);
    access(0, 1'b1, 32'd3, 32'd7, 3);
    check("hold_after_write", rd_a, 32'd20);

    // Back-to-back requests: enable held over 10 rising edges.
    @(negedge clk);
    en_a = 1'b1; op_a = 1'b0; mar_a = 32'd1;
    e.data = 32'd5; e.err = 1'b0;
    repeat (3) q_a.push_back(e);
    last_a = 32'd5;
    nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy_a) nrdy++;
    end
    en_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy_a) nrdy++;
    end
    check("hold_count", 32'(nrdy), 32'd3);

    // Reset during WAIT aborts the write.
    access(0, 1'b1, 32'd4, 32'h0000_0011, 3);
    @(negedge clk);
    en_a = 1'b1; op_a = 1'b1; mar_a = 32'd4; wd_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    en_a = 1'b0;
    @(negedge clk);
    check("busy_in_wait", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(rdy_a), 32'd0);
    check("abort_mbr_in", rd_a, 32'd0);
    rst = 1'b0;
    last_a = '0; last_b = '0;
    access(0, 1'b0, 32'd4, 32'd0, 3);
    access(0, 1'b0, 32'd1, 32'd0, 3);

    // Zero wait states.
    access(1, 1'b1, 32'd1, 32'd5, 1);
    access(1, 1'b0, 32'd1, 32'd0, 1);

    // Address 1025 aliases word 1 unless bounds checking is built in.
`ifdef MEM_BOUNDS_CHECK_EN
    access(0, 1'b1, 32'd1025, 32'd9, 3);
    access(0, 1'b0, 32'd1, 32'd0, 3);
    access(0, 1'b0, 32'd1025, 32'd0, 3);
`else
    access(0, 1'b0, 32'd1025, 32'd0, 3);
`endif

    repeat (2) @(negedge clk);
    check("sb_leftover_a", 32'(q_a.size()), 32'd0);
    check("sb_leftover_b", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
